maxpool_ctrl: RTL and testbench

Streaming controller that sequences the combinational 6x6→3x3 max-pooling datapath. It gathers a 6x6 feature map of 16-bit unsigned values arriving one pixel per handshake in raster order into a frame buffer. It then latches the nine 2x2-max results and streams them out one per handshake in raster order. It sits between the convolution output stream and the next layer's input stream.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/maxpool_ctrl_pool.sv | 24 ++
 rtl/maxpool_ctrl.sv | 92 +++++++++
 tb/tb_maxpool_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared feature-map constants, pixel type and pooling controller states
package cnn_pkg;

    localparam int PIX_W      = 16;
    localparam int FM_IN_DIM  = 6;
    localparam int FM_OUT_DIM = 3;
    localparam int FM_IN_PIX  = 36;
    localparam int FM_OUT_PIX = 9;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        POOL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/maxpool_ctrl_pool.sv
// rtl/maxpool_ctrl_pool.sv - combinational 6x6 to 3x3 2x2-max pooling datapath
module maxpool_ctrl_pool
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [FM_IN_PIX-1:0][DATA_W-1:0]  fm,
    output logic [FM_OUT_PIX-1:0][DATA_W-1:0] res
);

    // Strict greater-than keeps the earlier operand on ties.
    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    for (genvar i = 0; i < FM_OUT_DIM; i++) begin : g_row
        for (genvar j = 0; j < FM_OUT_DIM; j++) begin : g_col
            localparam int B = 2 * i * FM_IN_DIM + 2 * j;
            assign res[i*FM_OUT_DIM+j] = max2(max2(max2(fm[B], fm[B+1]), fm[B+FM_IN_DIM]),
                                              fm[B+FM_IN_DIM+1]);
        end
    end

endmodule

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - frame-buffered 6x6 max-pool sequencer with valid/ready streams
module maxpool_ctrl
    import cnn_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    state_t state, state_nxt;
    logic [5:0] in_cnt;
    logic [3:0] out_cnt;
    logic [FM_IN_PIX-1:0][DATA_W-1:0]  fm_buf;
    logic [FM_OUT_PIX-1:0][DATA_W-1:0] pool_res;
    logic [FM_OUT_PIX-1:0][DATA_W-1:0] res_q;
    logic in_fire, out_fire, in_at_end, out_at_end;

    assign in_fire    = in_valid && (state == LOAD);
    assign out_fire   = out_ready && (state == DRAIN);
    assign in_at_end  = (in_cnt == 6'(FM_IN_PIX - 1));
    assign out_at_end = (out_cnt == 4'(FM_OUT_PIX - 1));

    maxpool_ctrl_pool #(.DATA_W(DATA_W)) u_pool (
        .fm  (fm_buf),
        .res (pool_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && in_at_end) state_nxt = POOL;
            POOL:    state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_at_end) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Framing is driven purely by in_cnt; in_last is only audited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            fm_buf    <= '0;
            res_q     <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done      <= out_fire && out_at_end;
            frame_err <= in_fire && (in_last != in_at_end);
            if (in_fire) begin
                fm_buf[in_cnt] <= in_data;
                in_cnt         <= in_at_end ? 6'd0 : in_cnt + 6'd1;
            end
            if (state == POOL) begin
                res_q   <= pool_res;
                out_cnt <= 4'd0;
            end
            if (out_fire) begin
                out_cnt <= out_at_end ? 4'd0 : out_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state != LOAD);
        out_last  = (state == DRAIN) && out_at_end;
        out_data  = (state == DRAIN) ? res_q[out_cnt] : '0;
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb/tb_maxpool_ctrl.sv - randomized self-checking bench for maxpool_ctrl
module tb_maxpool_ctrl;
    import cnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;

    pix_t frame [36];
    pix_t expv  [9];

    maxpool_ctrl #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: each output is the largest of its 2x2 window, read straight from the image.
    task automatic model_pool();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix_t m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (frame[(2*r+dr)*6 + 2*c+dc] > m) m = frame[(2*r+dr)*6 + 2*c+dc];
                expv[r*3+c] = m;
            end
        end
    endtask

    task automatic push_frame(input bit gaps, input int bad_last_at, input bit drop_final_last,
                              output int errs);
        errs = 0;
        for (int k = 0; k < 36; k++) begin
            int guard = 0;
            while (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                step();
                if (frame_err) errs++;
            end
            in_valid = 1'b1;
            in_data  = frame[k];
            in_last  = (k == 35) ? !drop_final_last : (k == bad_last_at);
            while (!in_ready && guard < 100) begin
                step();
                guard++;
            end
            vectors++;
            if (!in_ready) begin
                miscompares++;
                $display("FAIL load_ready beat=%0d in_ready=%b required=1", k, in_ready);
            end
            step();
            if (frame_err) errs++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pool_cycle out_valid=%b busy=%b in_ready=%b required 0/1/0",
                     out_valid, busy, in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_out_latency out_valid=%b required=1", out_valid);
        end
    endtask

    task automatic drain_check(input string tag, input int stall_at, input int stall_len,
                               input bit rnd_ready);
        int idx = 0, cyc = 0, stalled = 0;
        while (idx < 9 && cyc < 500) begin
            if (idx == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            vectors++;
            if (out_valid !== 1'b1 || out_data !== expv[idx] || out_last !== (idx == 8)
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_out idx=%0d valid=%b data=%h last=%b in_ready=%b required 1/%h/%b/0",
                         tag, idx, out_valid, out_data, out_last, in_ready, expv[idx], idx == 8);
            end
            if (out_ready) idx++;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (idx != 9) begin
            miscompares++;
            $display("FAIL %s_timeout results=%0d required=9", tag, idx);
        end
        vectors++;
        if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done done=%b in_ready=%b out_valid=%b required 1/1/0",
                     tag, done, in_ready, out_valid);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done_pulse done=%b required=0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'h0
            || busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state rdy=%b vld=%b last=%b data=%h busy=%b done=%b ferr=%b required 1/0/0/0000/0/0/0",
                     in_ready, out_valid, out_last, out_data, busy, done, frame_err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_frame(input string tag, input bit gaps, input int stall_at,
                             input int stall_len, input bit rnd_ready);
        int errs;
        model_pool();
        push_frame(gaps, -1, 1'b0, errs);
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL %s_frame_err pulses=%0d required=0", tag, errs);
        end
        drain_check(tag, stall_at, stall_len, rnd_ready);
    endtask

    task automatic test_ascending();
        for (int k = 0; k < 36; k++) frame[k] = pix_t'(k);
        run_frame("ascending", 1'b0, -1, 0, 1'b0);
        vectors++;
        if (expv[0] !== 16'd7 || expv[8] !== 16'd35) begin
            miscompares++;
            $display("FAIL ascending_model first=%0d last=%0d required 7/35", expv[0], expv[8]);
        end
    endtask

    task automatic test_descending();
        for (int k = 0; k < 36; k++) frame[k] = pix_t'(35 - k);
        run_frame("descending", 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_unsigned();
        for (int k = 0; k < 36; k++) frame[k] = 16'h7FFF;
        frame[7] = 16'hFFFF;
        run_frame("unsigned", 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 36; k++) frame[k] = 16'($urandom);
        run_frame("backpressure", 1'b1, 4, 5, 1'b0);
    endtask

    task automatic test_frame_err();
        int errs;
        for (int k = 0; k < 36; k++) frame[k] = 16'($urandom);
        model_pool();
        push_frame(1'b0, 20, 1'b1, errs);
        vectors++;
        if (errs != 2) begin
            miscompares++;
            $display("FAIL frame_err_count pulses=%0d required=2", errs);
        end
        drain_check("frame_err", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int errs;
        for (int k = 0; k < 36; k++) frame[k] = 16'($urandom);
        model_pool();
        push_frame(1'b0, -1, 1'b0, errs);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== expv[3]) begin
            miscompares++;
            $display("FAIL mid_drain_pos valid=%b data=%h required 1/%h", out_valid, out_data, expv[3]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset valid=%b busy=%b in_ready=%b data=%h required 0/0/1/0000",
                     out_valid, busy, in_ready, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 36; k++) frame[k] = pix_t'(k);
        run_frame("after_reset", 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 36; k++)
                frame[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                       : 16'($urandom);
            run_frame("random", 1'b1, -1, 0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 36; k++) frame[k] = 16'($urandom);
        run_frame("b2b_a", 1'b0, -1, 0, 1'b0);
        for (int k = 0; k < 36; k++) frame[k] = 16'($urandom);
        run_frame("b2b_b", 1'b0, -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_unsigned();
        test_backpressure();
        test_frame_err();
        test_reset_mid_drain();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
